// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Definitions shared by the farm-road traffic-light controller and its roadside
// sensor interfaces.
//   sensor_state_t     : request FSM encoding (IDLE / WAIT / HOLDOFF)
//   DEBOUNCE_CYC_DEF   : default stable-cycle count for input debouncing
//   HOLDOFF_CYC_DEF    : default request hold-off after the controller serves
//   CNT_W_DEF          : default width of the waiting-vehicle counter
//   width_min1()       : bits needed to hold 0..v-1, never less than one bit
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLDOFF = 2'd2
    } sensor_state_t;

    localparam int DEBOUNCE_CYC_DEF = 16;
    localparam int HOLDOFF_CYC_DEF  = 50;
    localparam int CNT_W_DEF        = 8;

    // $clog2(1) is 0, which cannot size a vector; clamp to one bit.
    function automatic int width_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sig_debounce.sv
// -----------------------------------------------------------------------------
// sig_debounce
// Two-flop synchroniser, stability filter and rising-edge detector for a slow,
// bouncy asynchronous input (inductive loop, pedestrian push button).
// The filtered level only changes after the synchronised input has differed
// from it for DEBOUNCE_CYC consecutive clocks.
// Ports:
//   clk        in   system clock, posedge
//   reset      in   asynchronous active-low reset
//   sig_raw    in   raw asynchronous input
//   rise_now   out  combinational strobe: the filtered level rises on the
//                   coming clock edge
//   rise_pulse out  registered one-cycle pulse, high in the cycle after the
//                   edge on which the filtered level rose
// -----------------------------------------------------------------------------
module sig_debounce
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_raw,
    output logic rise_now,
    output logic rise_pulse
);

    localparam int SYNC_STAGES = 2;
    localparam int CW          = width_min1(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    generate
        if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
            $error("sig_debounce: DEBOUNCE_CYC must be at least 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s2;
    logic                   filt_reg, filt_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic                   rise_pulse_reg;

    assign s2 = sync_reg[SYNC_STAGES-1];

    // The counter measures how long s2 has disagreed with the filtered level;
    // any agreement restarts the measurement, so short glitches are absorbed.
    always_comb begin
        cnt_next  = cnt_reg;
        filt_next = filt_reg;
        rise_now  = 1'b0;
        if (s2 == filt_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
            filt_next = s2;
            cnt_next  = '0;
            rise_now  = s2;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg       <= '0;
            filt_reg       <= 1'b0;
            cnt_reg        <= '0;
            rise_pulse_reg <= 1'b0;
        end else begin
            sync_reg       <= {sync_reg[SYNC_STAGES-2:0], sig_raw};
            filt_reg       <= filt_next;
            cnt_reg        <= cnt_next;
            rise_pulse_reg <= rise_now;
        end
    end

    assign rise_pulse = rise_pulse_reg;

endmodule

// File: rtl/vehicle_sensor_if.sv
// -----------------------------------------------------------------------------
// vehicle_sensor_if
// Roadside end of the farm-road car-detect interface. Cleans up the raw loop
// detector, counts waiting vehicles and holds a request level (cin of the
// light controller) until the controller acknowledges service, then keeps the
// request low for a hold-off window.
// Parameters:
//   DEBOUNCE_CYC  stable cycles before the filtered loop level changes (>= 2)
//   HOLDOFF_CYC   cycles car_req is forced low after serve_ack (>= 1)
//   CNT_W         width of the waiting-vehicle counter
// Ports:
//   clk        in   system clock, posedge
//   reset      in   asynchronous active-low reset, synchronous release
//   loop_raw   in   raw loop detector, asynchronous and bouncy
//   serve_ack  in   one-cycle pulse: farm-road green has started
//   car_req    out  registered request level to the controller
//   det_pulse  out  one-cycle pulse per debounced vehicle arrival
//   car_count  out  vehicles detected since last serve_ack, saturating
//   overflow   out  sticky: an arrival occurred while car_count was at max
// -----------------------------------------------------------------------------
module vehicle_sensor_if
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int HOLDOFF_CYC  = HOLDOFF_CYC_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             loop_raw,
    input  logic             serve_ack,
    output logic             car_req,
    output logic             det_pulse,
    output logic [CNT_W-1:0] car_count,
    output logic             overflow
);

    localparam int HW = width_min1(HOLDOFF_CYC);
    localparam logic [HW-1:0]    HOLD_LOAD = HW'(HOLDOFF_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    generate
        if (HOLDOFF_CYC < 1) begin : g_bad_holdoff
            $error("vehicle_sensor_if: HOLDOFF_CYC must be at least 1");
        end
    endgenerate

    logic arrival;        // filtered loop rises on this edge
    logic det_pulse_int;  // registered copy of arrival

    sig_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_loop_debounce (
        .clk        (clk),
        .reset      (reset),
        .sig_raw    (loop_raw),
        .rise_now   (arrival),
        .rise_pulse (det_pulse_int)
    );

    sensor_state_t    state_reg, state_next;
    logic [HW-1:0]    holdoff_reg, holdoff_next;
    logic             car_req_reg;
    logic [CNT_W-1:0] car_count_reg, car_count_next;
    logic             overflow_reg, overflow_next;

    // -------------------------------------------------------------------------
    // Waiting-vehicle counter. An acknowledge empties the queue, but a vehicle
    // detected on that very edge belongs to the next service round.
    // -------------------------------------------------------------------------
    always_comb begin
        car_count_next = car_count_reg;
        overflow_next  = overflow_reg;
        if (serve_ack) begin
            car_count_next = arrival ? CNT_W'(1) : '0;
            overflow_next  = 1'b0;
        end else if (arrival) begin
            if (car_count_reg == CNT_MAX) begin
                overflow_next = 1'b1;
            end else begin
                car_count_next = car_count_reg + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Request FSM. It reacts to the registered arrival pulse, so car_req rises
    // one edge after det_pulse. Acks outside WAIT do not touch the timer.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        holdoff_next = holdoff_reg;
        case (state_reg)
            ST_IDLE: begin
                if (det_pulse_int) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (serve_ack) begin
                    state_next   = ST_HOLDOFF;
                    holdoff_next = HOLD_LOAD;
                end
            end
            ST_HOLDOFF: begin
                if (holdoff_reg == '0) begin
                    // Vehicles that arrived during hold-off re-raise the request.
                    state_next = (car_count_reg != '0) ? ST_WAIT : ST_IDLE;
                end else begin
                    holdoff_next = holdoff_reg - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            holdoff_reg   <= '0;
            car_req_reg   <= 1'b0;
            car_count_reg <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            holdoff_reg   <= holdoff_next;
            // Decoded from the next state so the level moves with the state.
            car_req_reg   <= (state_next == ST_WAIT);
            car_count_reg <= car_count_next;
            overflow_reg  <= overflow_next;
        end
    end

    assign car_req   = car_req_reg;
    assign det_pulse = det_pulse_int;
    assign car_count = car_count_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_vehicle_sensor_if.sv
// -----------------------------------------------------------------------------
// tb_vehicle_sensor_if
// Directed scenarios with literal expectations, followed by a randomized loop /
// acknowledge / reset run. A behavioural model of the sensor is compared with
// the DUT outputs on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_vehicle_sensor_if;

    localparam int D    = 4;
    localparam int H    = 8;
    localparam int W    = 3;
    localparam int CMAX = (1 << W) - 1;

    logic         clk       = 1'b0;
    logic         reset     = 1'b0;
    logic         loop_raw  = 1'b0;
    logic         serve_ack = 1'b0;
    logic         car_req;
    logic         det_pulse;
    logic [W-1:0] car_count;
    logic         overflow;

    vehicle_sensor_if #(
        .DEBOUNCE_CYC (D),
        .HOLDOFF_CYC  (H),
        .CNT_W        (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .loop_raw  (loop_raw),
        .serve_ack (serve_ack),
        .car_req   (car_req),
        .det_pulse (det_pulse),
        .car_count (car_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model. Debounce is described as "the last D synchronised
    // samples since the last level change all disagree with the level";
    // the request is a mode (0 idle, 1 requesting, 2 hold-off) plus a
    // remaining hold-off length.
    // ---------------------------------------------------------------------
    bit m_s1 = 0, m_s2 = 0, m_filt = 0, m_det = 0, m_ovf = 0;
    int m_count = 0, m_mode = 0, m_left = 0;
    bit hist[$];

    always @(posedge clk or negedge reset) begin : model
        bit s2o, deto, arrival, all_diff;
        int cnto;
        if (!reset) begin
            m_s1 = 0; m_s2 = 0; m_filt = 0; m_det = 0; m_ovf = 0;
            m_count = 0; m_mode = 0; m_left = 0;
            hist.delete();
        end else begin
            s2o  = m_s2;
            deto = m_det;
            cnto = m_count;
            m_s2 = m_s1;
            m_s1 = loop_raw;

            hist.push_back(s2o);
            if (hist.size() > D) void'(hist.pop_front());
            arrival = 0;
            if (hist.size() == D) begin
                all_diff = 1;
                foreach (hist[i]) if (hist[i] == m_filt) all_diff = 0;
                if (all_diff) begin
                    m_filt  = !m_filt;
                    arrival = m_filt;
                    hist.delete();
                end
            end
            m_det = arrival;

            case (m_mode)
                0: if (deto) m_mode = 1;
                1: if (serve_ack) begin m_mode = 2; m_left = H - 1; end
                default: begin
                    if (m_left == 0) m_mode = (cnto != 0) ? 1 : 0;
                    else m_left--;
                end
            endcase

            if (serve_ack) begin
                m_count = arrival ? 1 : 0;
                m_ovf   = 0;
            end else if (arrival) begin
                if (m_count == CMAX) m_ovf = 1;
                else m_count++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_car_req",   car_req,   (m_mode == 1) ? 1 : 0);
            check("model_det_pulse", det_pulse, m_det);
            check("model_car_count", car_count, m_count);
            check("model_overflow",  overflow,  m_ovf);
            if (det_pulse)
                $display("arrival: car_count=%0d overflow=%0d car_req=%0d", car_count, overflow, car_req);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic arrive_clean();
        loop_raw = 1'b1;
        repeat (7) @(negedge clk);
        loop_raw = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        #1;
        check("rst_car_req",   car_req,   0);
        check("rst_det_pulse", det_pulse, 0);
        check("rst_car_count", car_count, 0);
        check("rst_overflow",  overflow,  0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // 1: glitch shorter than the debounce window
        loop_raw = 1'b1;
        repeat (3) @(negedge clk);
        loop_raw = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("glitch_det", det_pulse, 0);
            check("glitch_cnt", car_count, 0);
            check("glitch_req", car_req, 0);
        end

        // 2: clean arrival latency
        @(negedge clk);
        loop_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("arr_det", det_pulse, (k == 6) ? 1 : 0);
            check("arr_cnt", car_count, (k >= 6) ? 1 : 0);
            check("arr_req", car_req,   (k >= 7) ? 1 : 0);
        end
        loop_raw = 1'b0;
        repeat (8) @(negedge clk);

        // 3: acknowledge, hold-off, arrival during hold-off
        serve_ack = 1'b1;
        @(negedge clk);
        serve_ack = 1'b0;
        #1;
        check("ack_req", car_req, 0);
        check("ack_cnt", car_count, 0);
        loop_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("hold_req", car_req,   (k >= 8) ? 1 : 0);
            check("hold_cnt", car_count, (k >= 6) ? 1 : 0);
        end
        loop_raw = 1'b0;
        repeat (8) @(negedge clk);

        // 4: saturation and clear
        repeat (9) arrive_clean();
        #1;
        check("sat_cnt", car_count, CMAX);
        check("sat_ovf", overflow, 1);
        check("sat_req", car_req, 1);
        @(negedge clk);
        serve_ack = 1'b1;
        @(negedge clk);
        serve_ack = 1'b0;
        #1;
        check("clr_cnt", car_count, 0);
        check("clr_ovf", overflow, 0);
        check("clr_req", car_req, 0);
        repeat (10) @(negedge clk);

        // 5: acknowledge on the same edge as an arrival
        arrive_clean();
        loop_raw = 1'b1;
        repeat (5) @(negedge clk);
        serve_ack = 1'b1;
        @(negedge clk);
        serve_ack = 1'b0;
        #1;
        check("same_cnt", car_count, 1);
        check("same_ovf", overflow, 0);
        check("same_req", car_req, 0);
        loop_raw = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        check("same_rereq", car_req, 1);

        // 6: reset mid-operation with the loop held high
        repeat (4) arrive_clean();
        #1;
        check("pre_rst_cnt", car_count, 5);
        @(negedge clk);
        #2;
        loop_raw = 1'b1;
        reset    = 1'b0;
        #1;
        check("arst_req", car_req,   0);
        check("arst_det", det_pulse, 0);
        check("arst_cnt", car_count, 0);
        check("arst_ovf", overflow,  0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("rel_det", det_pulse, (k == 6) ? 1 : 0);
        end
        loop_raw = 1'b0;
        repeat (8) @(negedge clk);

        // Randomized run against the model
        for (int c = 0; c < 3000; ) begin
            int len;
            bit lvl;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 10);
            for (int j = 0; j < len; j++) begin
                loop_raw  = lvl;
                serve_ack = ($urandom_range(0, 11) == 0);
                if ($urandom_range(0, 599) == 0) begin
                    #2;
                    reset = 1'b0;
                    @(negedge clk);
                    reset = 1'b1;
                end
                @(negedge clk);
                c++;
            end
        end
        serve_ack = 1'b0;
        loop_raw  = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
